mul_booth_pp_stage: RTL

Radix-4 Booth partial-product generation stage for the RV64 M-extension multiplier in stage 3. It accepts operand pairs with an opcode and tag through a valid/ready handshake. It produces XLEN/2+1 sign-extended partial products, registered and in the unpacked-array shape consumed by the downstream `wallace_tree_addition` (num_mul = NUM_PP, N = PP_W). A two-entry elastic buffer (output register plus skid register) gives full throughput with a registered `in_ready`.

---
 rtl/mul_booth_pp_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/mul_booth_pp_stage.sv
// mul_booth_pp_stage: radix-4 Booth partial-product generator behind a two-entry skid buffer
module mul_booth_pp_stage #(
  parameter int XLEN = 64,
  parameter int TAG_W = 8,
  localparam int NUM_PP = XLEN / 2 + 1,
  localparam int PP_W = 2 * XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP_W-1:0]  out_pp [NUM_PP-1:0],
  output logic [2:0]       out_op,
  output logic [TAG_W-1:0] out_tag
);
  logic             rdy_q, skid_v, skid_nx, accept, drain, mulw, a_sgn, b_sgn;
  logic [XLEN-1:0]  skid_a, skid_b, a, b, ac, bc;
  logic [2:0]       skid_op, op;
  logic [TAG_W-1:0] skid_tag, tag;
  logic [XLEN:0]    a_ext;
  logic [XLEN+2:0]  b_pad;
  logic [PP_W-1:0]  a_sx;
  logic [PP_W-1:0]  pp [NUM_PP-1:0];
  assign in_ready = rdy_q && !rst;
  assign accept = in_valid && in_ready;
  assign drain = !out_valid || out_ready;
  assign skid_nx = skid_v ? !drain : accept && !drain;
  assign a = skid_v ? skid_a : in_a;
  assign b = skid_v ? skid_b : in_b;
  assign op = skid_v ? skid_op : in_op;
  assign tag = skid_v ? skid_tag : in_tag;
  assign mulw = op == 3'd4;
  assign a_sgn = op != 3'd3;
  assign b_sgn = op != 3'd2 && op != 3'd3;
  assign ac = mulw ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
  assign bc = mulw ? {{(XLEN-32){b[31]}}, b[31:0]} : b;
  assign a_ext = {a_sgn & ac[XLEN-1], ac};
  assign b_pad = {{2{b_sgn & bc[XLEN-1]}}, bc, 1'b0};
  assign a_sx = {{(PP_W-XLEN-1){a_ext[XLEN]}}, a_ext};
  for (genvar j = 0; j < NUM_PP; j++) begin : g_pp
    logic [2:0]      t;
    logic [PP_W-1:0] m;
    assign t = b_pad[2*j+2 -: 3];
    assign m = (t == 3'b011 || t == 3'b100) ? a_sx << 1 : (t == 3'b000 || t == 3'b111) ? '0 : a_sx;
    assign pp[j] = (t[2] ? -m : m) << (2 * j);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
      rdy_q <= 1'b1;
      out_op <= '0;
      out_tag <= '0;
      for (int i = 0; i < NUM_PP; i++) out_pp[i] <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      skid_v <= skid_nx;
      rdy_q <= !skid_nx;
      if (drain) out_valid <= skid_v || accept;
      if (drain && (skid_v || accept)) begin
        out_pp <= pp;
        out_op <= op;
        out_tag <= tag;
      end
      if (!skid_v && accept && !drain) begin
        skid_a <= in_a;
        skid_b <= in_b;
        skid_op <= in_op;
        skid_tag <= in_tag;
      end
    end
  end
endmodule
